// File: rtl/gnw_pkg.sv
// Shared types and constants for the gnw core's HPS ioctl helpers.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package gnw_pkg;

   // ioctl_index the save/high-score upload path answers to
   localparam logic [7:0] INDEX_SAVE = 8'd1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      FETCH = 3'd2,
      READY = 3'd3,
      DRAIN = 3'd4
   } upload_state_t;

   // Words at or beyond the save area length are served as zero without touching memory
   function automatic logic word_in_range(input logic [23:0] word, input logic [15:0] len);
      return word < {8'd0, len};
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a rising-edge detector.
// Latency: rise is valid 2 clocks after the input edge (combinational off the synced flops).
// Backpressure: none; rise is a single-cycle pulse.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_d;

   // Metastability chain plus one delay stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= d;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rise = sync & ~sync_d;

endmodule

// File: rtl/gnw_ioctl_uploader.sv
// Serves core memory (save RAM / high scores) to the HPS during ioctl_upload, 16-bit words.
// Latency: ioctl_upload_req 3 clocks after save_trigger; data 1 clock after mem_ack (1 clock if out of range).
// Backpressure: holds ioctl_wait while a word is being fetched; mem_rd held until mem_ack.
module gnw_ioctl_uploader
   import gnw_pkg::*;
#(
   parameter logic [7:0]  INDEX       = INDEX_SAVE,
   parameter int          ADDR_WIDTH  = 16,
   parameter logic [15:0] LEN_WORDS   = 16'd1024,
   parameter logic [23:0] REQ_TIMEOUT = 24'hFFFFFF
) (
   input  logic                  clk_sys_99_287,
   input  logic                  reset_n,
   input  logic                  save_trigger,
   output logic                  ioctl_upload_req,
   input  logic                  ioctl_upload,
   input  logic [7:0]            ioctl_index,
   input  logic                  ioctl_rd,
   input  logic [24:0]           ioctl_addr,
   output logic [15:0]           ioctl_din,
   output logic                  ioctl_wait,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [15:0]           mem_data,
   output logic                  busy
);

   upload_state_t state, state_n;
   logic [23:0]   word_addr, word_addr_n;
   logic [23:0]   req_cnt, req_cnt_n;
   logic          pending, pending_n;
   logic          match_d;
   logic [15:0]   din_n;
   logic          trig_rise;
   logic          match;
   logic          match_rise;
   logic [23:0]   start_word;
   logic          addr_lsb_unused;

   // Byte address LSB is meaningless for a 16-bit port
   assign addr_lsb_unused = ioctl_addr[0];

   assign match      = ioctl_upload && (ioctl_index == INDEX);
   assign match_rise = match && !match_d;
   assign start_word = ioctl_addr[24:1];

   sync_edge u_trig_sync (
      .clk   (clk_sys_99_287),
      .rst_n (reset_n),
      .d     (save_trigger),
      .rise  (trig_rise)
   );

   // State, bookkeeping and registered outputs, all derived from the next state
   always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         word_addr        <= '0;
         req_cnt          <= '0;
         pending          <= 1'b0;
         match_d          <= 1'b0;
         ioctl_din        <= '0;
         ioctl_upload_req <= 1'b0;
         ioctl_wait       <= 1'b0;
         mem_rd           <= 1'b0;
         mem_addr         <= '0;
         busy             <= 1'b0;
      end else begin
         state            <= state_n;
         word_addr        <= word_addr_n;
         req_cnt          <= req_cnt_n;
         pending          <= pending_n;
         match_d          <= match;
         ioctl_din        <= din_n;
         ioctl_upload_req <= (state_n == REQ);
         ioctl_wait       <= (state_n == FETCH);
         mem_rd           <= ((state_n == FETCH) && word_in_range(word_addr_n, LEN_WORDS)) ||
                             (state_n == DRAIN);
         mem_addr         <= word_addr_n[ADDR_WIDTH-1:0];
         busy             <= (state_n != IDLE);
      end
   end

   // Next-state logic: request, fetch/serve loop, and draining an abandoned read
   always_comb begin
      state_n     = state;
      word_addr_n = word_addr;
      req_cnt_n   = req_cnt;
      pending_n   = pending | trig_rise;
      din_n       = ioctl_din;
      case (state)
         IDLE: begin
            if (match_rise) begin
               state_n     = FETCH;
               word_addr_n = start_word;
            end else if (pending || trig_rise) begin
               state_n   = REQ;
               req_cnt_n = REQ_TIMEOUT;
               pending_n = 1'b0;
            end
         end
         REQ: begin
            if (match_rise) begin
               state_n     = FETCH;
               word_addr_n = start_word;
            end else if (req_cnt == 24'd0) begin
               state_n = IDLE;
            end else begin
               req_cnt_n = req_cnt - 24'd1;
            end
         end
         FETCH: begin
            if (!word_in_range(word_addr, LEN_WORDS)) begin
               if (ioctl_upload) begin
                  din_n   = 16'd0;
                  state_n = READY;
               end else begin
                  state_n = IDLE;
               end
            end else if (mem_ack) begin
               // Data arriving after the HPS gave up is discarded
               if (ioctl_upload) begin
                  din_n   = mem_data;
                  state_n = READY;
               end else begin
                  state_n = IDLE;
               end
            end else if (!ioctl_upload) begin
               state_n = DRAIN;
            end
         end
         READY: begin
            if (!ioctl_upload) begin
               state_n = IDLE;
            end else if (ioctl_rd) begin
               state_n     = FETCH;
               word_addr_n = word_addr + 24'd1;
            end
         end
         DRAIN: begin
            if (mem_ack) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
